// File: rtl/nios2_oci_dct_trace_buffer.sv
// Circular debug-trace capture buffer: freezes POST_TRIG entries after test_ending, then drains oldest-first.
// Optional per-entry cycle timestamps are enabled by defining OCI_TRACE_TIMESTAMP_EN.
module nios2_oci_dct_trace_buffer #(
   parameter int unsigned DATA_W    = 30,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned POST_TRIG = 4,
   parameter int unsigned OVF_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         dct_buffer,
   input  logic [CNT_W-1:0]          dct_count,
   input  logic                      dct_valid,
   input  logic                      test_ending,
   input  logic                      rearm,
   output logic                      test_has_ended,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [DATA_W+CNT_W-1:0]   rd_data,
   output logic                      rd_last,
   output logic [ADDR_W:0]           fill,
   output logic [OVF_W-1:0]          ovf_count,
   output logic [15:0]               rd_ts
);
   localparam int unsigned DEPTH  = 2**ADDR_W;
   localparam int unsigned ENT_W  = DATA_W + CNT_W;
   localparam int unsigned FILL_W = ADDR_W + 1;
   localparam logic [ADDR_W:0] FULL = FILL_W'(DEPTH);

   typedef enum logic [1:0] {ARMED, POST, DONE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
   logic [ADDR_W-1:0]   post_cnt, post_cnt_nxt;
   logic [ADDR_W:0]     fill_nxt;
   logic [OVF_W-1:0]    ovf_nxt;
   logic                wr_en, byp;
   logic [ENT_W-1:0]    wr_word;
   logic [ENT_W-1:0]    mem [DEPTH];

   assign wr_word = {dct_count, dct_buffer};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ARMED;
      else       state <= state_nxt;
   end

   // Next-state, pointer and occupancy update
   always_comb begin
      state_nxt    = state;
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      fill_nxt     = fill;
      post_cnt_nxt = post_cnt;
      ovf_nxt      = ovf_count;
      wr_en        = dct_valid && (dct_count != '0) && (state != DONE);
      if (wr_en) begin
         wr_ptr_nxt = wr_ptr + ADDR_W'(1);
         if (fill != FULL) fill_nxt = fill + FILL_W'(1);
      end
      case (state)
         ARMED: begin
            if (wr_en && (fill == FULL) && (ovf_count != '1)) ovf_nxt = ovf_count + OVF_W'(1);
            if (test_ending) begin
               post_cnt_nxt = '0;
               state_nxt    = (POST_TRIG == 0) ? DONE : POST;
            end
         end
         POST: begin
            if (wr_en) begin
               post_cnt_nxt = post_cnt + ADDR_W'(1);
               if (post_cnt_nxt == ADDR_W'(POST_TRIG)) state_nxt = DONE;
            end
         end
         DONE: begin
            if (rearm) begin
               state_nxt    = ARMED;
               fill_nxt     = '0;
               post_cnt_nxt = '0;
               ovf_nxt      = '0;
            end else if (rd_valid && rd_ready) begin
               rd_ptr_nxt = rd_ptr + ADDR_W'(1);
               fill_nxt   = fill - FILL_W'(1);
            end
         end
         default: state_nxt = ARMED;
      endcase
      // Entering DONE: point at the oldest held entry
      if ((state != DONE) && (state_nxt == DONE)) rd_ptr_nxt = wr_ptr_nxt - ADDR_W'(fill_nxt);
   end

   // Final write may land on the oldest slot when only one entry is held
   assign byp = wr_en && (wr_ptr == rd_ptr_nxt);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fill           <= '0;
         post_cnt       <= '0;
         ovf_count      <= '0;
         test_has_ended <= 1'b0;
         rd_valid       <= 1'b0;
         rd_last        <= 1'b0;
         rd_data        <= '0;
      end else begin
         wr_ptr         <= wr_ptr_nxt;
         rd_ptr         <= rd_ptr_nxt;
         fill           <= fill_nxt;
         post_cnt       <= post_cnt_nxt;
         ovf_count      <= ovf_nxt;
         test_has_ended <= (state_nxt == DONE);
         rd_valid       <= (state_nxt == DONE) && (fill_nxt != '0);
         rd_last        <= (state_nxt == DONE) && (fill_nxt == FILL_W'(1));
         if (state_nxt == DONE) rd_data <= byp ? wr_word : mem[rd_ptr_nxt];
      end
   end

`ifdef OCI_TRACE_TIMESTAMP_EN
   logic [15:0] ts_cnt;
   logic [15:0] ts_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) ts_mem[wr_ptr] <= ts_cnt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  rd_ts <= '0;
      else if (state_nxt == DONE) rd_ts <= byp ? ts_cnt : ts_mem[rd_ptr_nxt];
   end
`else
   assign rd_ts = '0;
`endif

endmodule
